// File: rtl/iq_output_buffer.sv
// Rounds and saturates CIC I/Q samples to OUT_W bits, stages them one cycle,
// and queues them in a first-word-fall-through FIFO with sticky overflow tracking.
module iq_output_buffer #(
  parameter int IN_W  = 68,
  parameter int OUT_W = 16,
  parameter int SHIFT = 52,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [IN_W-1:0]      cic_i_i,
  input  logic [IN_W-1:0]      cic_q_i,
  input  logic                 cic_valid_i,
  output logic [2*OUT_W-1:0]   iq_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [CW-1:0]        count_o,
  output logic                 overflow_o,
  output logic [7:0]           drop_cnt_o,
  input  logic                 clear_ovf_i
);

  localparam logic signed [IN_W:0] RND     = {{IN_W{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [IN_W:0] SAT_MAX = {{(IN_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [IN_W:0] SAT_MIN = {{(IN_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};

  // Round half toward +inf, then clamp into the signed OUT_W range.
  function automatic logic [OUT_W-1:0] round_sat(input logic [IN_W-1:0] x);
    logic signed [IN_W:0] ext;
    logic signed [IN_W:0] sum;
    logic signed [IN_W:0] shr;
    ext = {x[IN_W-1], x};
    sum = ext + RND;
    shr = sum >>> SHIFT;
    if (shr > SAT_MAX)      round_sat = SAT_MAX[OUT_W-1:0];
    else if (shr < SAT_MIN) round_sat = SAT_MIN[OUT_W-1:0];
    else                    round_sat = shr[OUT_W-1:0];
  endfunction

  logic [2*OUT_W-1:0] mem_q [DEPTH];

  logic               stage_valid_q, stage_valid_d;
  logic [2*OUT_W-1:0] stage_iq_q, stage_iq_d;
  logic [CW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]      rd_ptr_q, rd_ptr_d;
  logic               overflow_q, overflow_d;
  logic [7:0]         drop_cnt_q, drop_cnt_d;

  logic [CW-1:0]      count;
  logic               empty;
  logic               full;
  logic               pop;
  logic               push;
  logic               drop;

  // Output handshake: the head in iq_o is transferred on any rising edge where
  // valid_o and ready_i are both 1; ready_i has no effect while valid_o is 0.
  always_comb begin
    count = wr_ptr_q - rd_ptr_q;
    empty = (count == '0);
    full  = (count == CW'(DEPTH));
    pop   = !empty && ready_i;
    push  = stage_valid_q && (!full || pop);
    drop  = stage_valid_q && full && !pop;

    stage_valid_d = cic_valid_i;
    stage_iq_d    = cic_valid_i ? {round_sat(cic_i_i), round_sat(cic_q_i)} : stage_iq_q;
    wr_ptr_d      = push ? wr_ptr_q + CW'(1) : wr_ptr_q;
    rd_ptr_d      = pop  ? rd_ptr_q + CW'(1) : rd_ptr_q;

    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      // A drop on the same edge as a clear restarts the count at one.
      overflow_d = 1'b1;
      if (clear_ovf_i)               drop_cnt_d = 8'd1;
      else if (drop_cnt_q != 8'hFF)  drop_cnt_d = drop_cnt_q + 8'd1;
    end else if (clear_ovf_i) begin
      overflow_d = 1'b0;
      drop_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stage_valid_q <= 1'b0;
      stage_iq_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      overflow_q    <= 1'b0;
      drop_cnt_q    <= 8'd0;
    end else begin
      stage_valid_q <= stage_valid_d;
      stage_iq_q    <= stage_iq_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      overflow_q    <= overflow_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && push) mem_q[wr_ptr_q[AW-1:0]] <= stage_iq_q;
  end

  always_comb begin
    valid_o    = !empty;
    iq_o       = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    count_o    = count;
    overflow_o = overflow_q;
    drop_cnt_o = drop_cnt_q;
  end

endmodule

// File: tb/tb_iq_output_buffer.sv
// Directed bench for iq_output_buffer: rounding, saturation, latency, overflow,
// full-with-pop streaming, drop counter saturation and mid-operation reset.
module tb_iq_output_buffer;

  localparam int IN_W  = 68;
  localparam int OUT_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [IN_W-1:0]   cic_i = '0;
  logic [IN_W-1:0]   cic_q = '0;
  logic              cic_valid = 1'b0;
  logic [2*OUT_W-1:0] iq;
  logic              valid;
  logic              ready = 1'b0;
  logic [4:0]        count;
  logic              overflow;
  logic [7:0]        drop_cnt;
  logic              clear_ovf = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [2*OUT_W-1:0] exp_q[$];

  iq_output_buffer dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cic_i_i     (cic_i),
    .cic_q_i     (cic_q),
    .cic_valid_i (cic_valid),
    .iq_o        (iq),
    .valid_o     (valid),
    .ready_i     (ready),
    .count_o     (count),
    .overflow_o  (overflow),
    .drop_cnt_o  (drop_cnt),
    .clear_ovf_i (clear_ovf)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic drive_pair(input logic [IN_W-1:0] i, input logic [IN_W-1:0] q);
    cic_i     = i;
    cic_q     = q;
    cic_valid = 1'b1;
  endtask

  task automatic send_pair(input logic [IN_W-1:0] i, input logic [IN_W-1:0] q);
    drive_pair(i, q);
    tick();
    cic_valid = 1'b0;
  endtask

  function automatic logic [IN_W-1:0] pos_k(input int k);
    return IN_W'(k) << 52;
  endfunction

  function automatic logic [IN_W-1:0] neg_k(input int k);
    return -(IN_W'(k) << 52);
  endfunction

  function automatic logic [2*OUT_W-1:0] pair_k(input int k);
    return {16'(k), 16'(-k)};
  endfunction

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [IN_W-1:0]    vi [4];
  logic [IN_W-1:0]    vq [4];
  logic [2*OUT_W-1:0] ve [4];

  initial begin
    tick();
    tick();
    rst = 1'b0;
    check_eq("rst_valid", valid, 0);
    check_eq("rst_count", count, 0);
    check_eq("rst_iq", iq, 0);
    check_eq("rst_ovf", overflow, 0);
    check_eq("rst_drop", drop_cnt, 0);

    // Rounding / saturation vectors, each one strobe into an empty FIFO with ready=1
    vi[0] = IN_W'(1) << 52;          vq[0] = IN_W'(3) << 51;        ve[0] = 32'h0001_0002;
    vi[1] = -(IN_W'(3) << 51);       vq[1] = (IN_W'(1) << 51) - 1;  ve[1] = 32'hFFFF_0000;
    vi[2] = (IN_W'(1) << 67) - 1;    vq[2] = IN_W'(1) << 67;        ve[2] = 32'h7FFF_8000;
    vi[3] = IN_W'(1) << 66;          vq[3] = -(IN_W'(1) << 66);     ve[3] = 32'h4000_C000;
    ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      send_pair(vi[n], vq[n]);
      check_eq("lat_stage_valid", valid, 0);
      tick();
      check_eq("lat_valid_hi", valid, 1);
      check_eq("round_iq", iq, ve[n]);
      tick();
      check_eq("lat_valid_lo", valid, 0);
      check_eq("lat_count0", count, 0);
    end

    // Overflow: 17 back-to-back strobes with ready low
    ready = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      drive_pair(pos_k(k), neg_k(k));
      if (k <= 16) exp_q.push_back(pair_k(k));
      tick();
    end
    cic_valid = 1'b0;
    tick();
    check_eq("ovf_count", count, 16);
    check_eq("ovf_flag", overflow, 1);
    check_eq("ovf_drop1", drop_cnt, 1);
    send_pair(pos_k(18), neg_k(18));
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    check_eq("clr_vs_drop_flag", overflow, 1);
    check_eq("clr_vs_drop_cnt", drop_cnt, 1);
    send_pair(pos_k(19), neg_k(19));
    tick();
    check_eq("ovf_drop2", drop_cnt, 2);
    ready = 1'b1;
    while (exp_q.size() > 0) begin
      check_eq("ovf_drain", iq, exp_q.pop_front());
      tick();
    end
    check_eq("ovf_empty_valid", valid, 0);
    check_eq("ovf_empty_count", count, 0);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    check_eq("clr_flag", overflow, 0);
    check_eq("clr_cnt", drop_cnt, 0);

    // Full FIFO streaming with a pop on every edge
    for (int k = 1; k <= 40; k++) begin
      ready = (k >= 18);
      drive_pair(pos_k(k), neg_k(k));
      exp_q.push_back(pair_k(k));
      if (k >= 18) begin
        check_eq("full_pop_count", count, 16);
        check_eq("full_pop_iq", iq, exp_q[0]);
      end
      tick();
      if (k >= 18) void'(exp_q.pop_front());
    end
    cic_valid = 1'b0;
    while (exp_q.size() > 0) begin
      check_eq("full_pop_drain", iq, exp_q.pop_front());
      tick();
    end
    check_eq("full_pop_valid_end", valid, 0);
    check_eq("full_pop_nodrop", drop_cnt, 0);
    check_eq("full_pop_noovf", overflow, 0);

    // Drop counter saturation
    ready = 1'b0;
    drive_pair(pos_k(1), neg_k(1));
    for (int c = 0; c < 300; c++) tick();
    cic_valid = 1'b0;
    tick();
    check_eq("drop_sat", drop_cnt, 255);
    check_eq("drop_sat_flag", overflow, 1);

    // Reset mid-operation with a concurrent strobe
    pulse_reset();
    check_eq("rst2_ovf", overflow, 0);
    check_eq("rst2_drop", drop_cnt, 0);
    check_eq("rst2_count", count, 0);
    for (int k = 1; k <= 5; k++) send_pair(pos_k(k), neg_k(k));
    tick();
    check_eq("mid_count5", count, 5);
    check_eq("mid_head", iq, pair_k(1));
    drive_pair(pos_k(9), neg_k(9));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cic_valid = 1'b0;
    check_eq("mid_rst_valid", valid, 0);
    check_eq("mid_rst_count", count, 0);
    check_eq("mid_rst_iq", iq, 0);
    tick();
    check_eq("mid_rst_ignored", count, 0);
    send_pair(pos_k(7), neg_k(7));
    check_eq("mid_post_stage", valid, 0);
    tick();
    check_eq("mid_post_valid", valid, 1);
    check_eq("mid_post_iq", iq, pair_k(7));

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
